mem_stage: RTL
==============

# mem_stage

MEM stage of the five-stage MIPS pipeline. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register, and holds the 4 KiB data memory. It performs word, halfword and byte stores and loads, with sign or zero extension, and flags misaligned or out-of-range accesses. It produces the write-back value, destination register and write enable that MEM/WB latches, and passes IR and PC through unchanged.

## Interface
Parameters:
- DEPTH_WORDS, 1024, number of 32-bit memory words. Valid byte addresses are 0 .. 4*DEPTH_WORDS-1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- IR_M  in  32  instruction in MEM.
- PC_M  in  32  PC of that instruction.
- ALU_M  in  32  ALU result; this is the effective byte address for loads and stores.
- RT_M  in  32  store data, already forwarded.
- RW_M  in  5  destination register.
- RegWr_M  in  1  register-write enable from decode.
- type_M  in  4  instruction class, passed through.
- IR_W, PC_W  out  32  copies of IR_M and PC_M.
- type_W  out  4  copy of type_M.
- RW  out  5  copy of RW_M.
- WB_W  out  32  write-back value.
- RegWr_W  out  1  RegWr_M gated by exceptions.
- adel  out  1  load address error.
- ades  out  1  store address error.

## Operation
- Opcode decode from IR_M[31:26]:
  - lw 100011, lb 100000, lbu 100100, lh 100001, lhu 100101.
  - sw 101011, sb 101000, sh 101001.
  - jal 000011; jalr is opcode 000000 with funct 001001.
  - Any other opcode is a non-memory instruction.
- Byte order is little-endian. Lane k = ALU_M[1:0] maps to word bits 8k+7:8k.
- Word index = ALU_M[31:2].
- Range check: the address is out of range when ALU_M >= 4*DEPTH_WORDS.
- Misalignment check:
  - lw/sw: misaligned when ALU_M[1:0] != 0.
  - lh/lhu/sh: misaligned when ALU_M[0] != 0.
  - Byte operations are never misaligned.
- adel = load AND (misaligned OR out of range).
- ades = store AND (misaligned OR out of range).
- Stores:
  - sw writes the whole word.
  - sh writes halfword ALU_M[1] with RT_M[15:0].
  - sb writes lane ALU_M[1:0] with RT_M[7:0].
  - Other bytes of the word are untouched.
  - A store with ades=1 writes nothing.
- Loads:
  - The word is read combinationally.
  - lb/lh sign-extend; lbu/lhu zero-extend.
  - When adel=1, load data = 0.
- WB_W selection:
  - load → load data.
  - jal/jalr → PC_M + 8, wrapping mod 2^32.
  - anything else → ALU_M.
- RegWr_W = RegWr_M AND NOT adel AND NOT ades.
- Pass-through outputs are purely combinational.

## Timing
- Reads have zero latency: load data is combinational from the array and ALU_M in the same cycle.
- A store takes effect at the rising edge that ends its MEM cycle. The next cycle's load from that address returns the new data.
- reset low at an edge:
  - Every memory word is cleared to 0; no store is performed at that edge, even if a valid store is present.
  - Storage reset value is 0. Outputs have no reset value of their own; they follow their inputs combinationally.
  - After reset, any load returns 0.
- reset high: normal store behaviour.
- Reset asserted mid-sequence: memory is cleared. The store presented on that edge is lost, and the store on the next edge with reset high is applied normally.
- Only one instruction is in MEM per cycle, so a load and a store never occur in the same cycle.
- adel and ades are combinational, valid in the same cycle as the instruction.

## Test plan
- Reset: hold reset=0 for one edge, then release and issue lw at 0x0, 0x10 and 0xFFC → WB_W=0, adel=0 each time.
- sw RT_M=0x12345678 @0x8, next cycle lw @0x8 → WB_W=0x12345678. lb @0x8 → 0x00000078; lb @0xB → 0x00000012.
- sb 0xFF @0x9 over that word, then lw @0x8 → 0x1234FF78. lb @0x9 → 0xFFFFFFFF; lbu @0x9 → 0x000000FF.
- sh 0x8001 @0xA, then lh @0xA → 0xFFFF8001 and lhu @0xA → 0x00008001. Then sh @0xB → ades=1, memory unchanged; lh @0x3 → adel=1, WB_W=0, RegWr_W=0.
- Out of range with DEPTH_WORDS=1024:
  - sw @0x1000 → ades=1, no write; a following lw @0x0 is unchanged.
  - lw @0x1000 → adel=1, WB_W=0.
  - jal with PC_M=0x3000 → WB_W=0x3008.
  - addu with ALU_M=0xDEADBEEF → WB_W=0xDEADBEEF, RegWr_W=RegWr_M.
- Reset mid-operation: drive sw 0xAA @0x4 on an edge with reset=0, then the same sw with reset=1, then lw @0x4 → reads 0xAA. Pulsing reset once more → lw @0x4 reads 0.

Source files
------------

// File: rtl/mem_stage_if.sv
// mem_stage_if: bundles the EX/MEM-side inputs and the MEM/WB-side outputs of
// the MEM pipeline stage.
//   master : drives IR_M, PC_M, ALU_M, RT_M, RW_M, RegWr_M, type_M and
//            observes IR_W, PC_W, type_W, RW, WB_W, RegWr_W, adel, ades.
//   slave  : the MEM stage itself (mirror directions).
interface mem_stage_if;
    logic [31:0] IR_M;
    logic [31:0] PC_M;
    logic [31:0] ALU_M;
    logic [31:0] RT_M;
    logic [4:0]  RW_M;
    logic        RegWr_M;
    logic [3:0]  type_M;

    logic [31:0] IR_W;
    logic [31:0] PC_W;
    logic [3:0]  type_W;
    logic [4:0]  RW;
    logic [31:0] WB_W;
    logic        RegWr_W;
    logic        adel;
    logic        ades;

    modport master (
        output IR_M, PC_M, ALU_M, RT_M, RW_M, RegWr_M, type_M,
        input  IR_W, PC_W, type_W, RW, WB_W, RegWr_W, adel, ades
    );

    modport slave (
        input  IR_M, PC_M, ALU_M, RT_M, RW_M, RegWr_M, type_M,
        output IR_W, PC_W, type_W, RW, WB_W, RegWr_W, adel, ades
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: MEM stage of a five-stage MIPS pipeline with a little-endian
// data memory of DEPTH_WORDS 32-bit words.
//   clk   : rising-edge clock
//   reset : synchronous active-low; clears every memory word, blocks stores
//   bus   : mem_stage_if.slave
//           in : IR_M, PC_M, ALU_M (byte address), RT_M (store data),
//                RW_M, RegWr_M, type_M
//           out: IR_W, PC_W, type_W, RW (pass-through), WB_W (write-back
//                value), RegWr_W (gated write enable), adel/ades (address
//                errors on load/store)
// Loads read combinationally; stores commit at the rising edge ending the
// MEM cycle.
module mem_stage #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    mem_stage_if.slave  bus
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    // One bit wider than the address so 4*DEPTH_WORDS never overflows.
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_LB      = 6'b100000;
    localparam logic [5:0] OP_LH      = 6'b100001;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_LBU     = 6'b100100;
    localparam logic [5:0] OP_LHU     = 6'b100101;
    localparam logic [5:0] OP_SB      = 6'b101000;
    localparam logic [5:0] OP_SH      = 6'b101001;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    logic [31:0] mem_array [DEPTH_WORDS];

    logic [5:0]    opcode;
    logic [5:0]    funct;
    logic          is_load;
    logic          is_store;
    logic          size_word;
    logic          size_half;
    logic          load_signed;
    logic          is_link;
    logic          in_range;
    logic          misaligned;
    logic          addr_err;
    logic          do_store;
    logic [1:0]    lane;
    logic [AW-1:0] word_idx;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   load_data;
    logic [3:0]    byte_en;
    logic [31:0]   wr_data;

    assign opcode   = bus.IR_M[31:26];
    assign funct    = bus.IR_M[5:0];
    assign lane     = bus.ALU_M[1:0];
    assign word_idx = bus.ALU_M[AW+1:2];

    always_comb begin
        is_load     = 1'b0;
        is_store    = 1'b0;
        size_word   = 1'b0;
        size_half   = 1'b0;
        load_signed = 1'b0;
        is_link     = 1'b0;
        case (opcode)
            OP_LW:      begin is_load = 1'b1; size_word = 1'b1; end
            OP_LH:      begin is_load = 1'b1; size_half = 1'b1; load_signed = 1'b1; end
            OP_LHU:     begin is_load = 1'b1; size_half = 1'b1; end
            OP_LB:      begin is_load = 1'b1; load_signed = 1'b1; end
            OP_LBU:     begin is_load = 1'b1; end
            OP_SW:      begin is_store = 1'b1; size_word = 1'b1; end
            OP_SH:      begin is_store = 1'b1; size_half = 1'b1; end
            OP_SB:      begin is_store = 1'b1; end
            OP_JAL:     begin is_link = 1'b1; end
            OP_SPECIAL: begin is_link = (funct == FN_JALR); end
            default:    ;
        endcase
    end

    assign in_range   = ({1'b0, bus.ALU_M} < ADDR_LIMIT);
    assign misaligned = (size_word && (lane != 2'b00)) || (size_half && lane[0]);
    assign addr_err   = !in_range || misaligned;
    assign bus.adel   = is_load && addr_err;
    assign bus.ades   = is_store && addr_err;
    assign do_store   = is_store && !addr_err;

    // Combinational read; word_idx is only meaningful when in_range, and the
    // result is discarded otherwise.
    assign rd_word = mem_array[word_idx];
    assign rd_byte = rd_word[8*lane +: 8];
    assign rd_half = bus.ALU_M[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_data = '0;
        if (!addr_err) begin
            if (size_word)
                load_data = rd_word;
            else if (size_half)
                load_data = {{16{load_signed & rd_half[15]}}, rd_half};
            else
                load_data = {{24{load_signed & rd_byte[7]}}, rd_byte};
        end
    end

    // Per-lane byte enables and replicated store data: halfwords and bytes
    // are copied into every matching lane so the enable alone picks the target.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign byte_en[gi] = size_word
                               || (size_half && (bus.ALU_M[1] == LANE[1]))
                               || (!size_word && !size_half && (lane == LANE));
            assign wr_data[8*gi +: 8] = size_word ? bus.RT_M[8*gi +: 8]
                                      : size_half ? bus.RT_M[8*(gi%2) +: 8]
                                      : bus.RT_M[7:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++)
                mem_array[i] <= '0;
        end else if (do_store) begin
            for (int b = 0; b < 4; b++)
                if (byte_en[b])
                    mem_array[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
    end

    assign bus.IR_W    = bus.IR_M;
    assign bus.PC_W    = bus.PC_M;
    assign bus.type_W  = bus.type_M;
    assign bus.RW      = bus.RW_M;
    assign bus.WB_W    = is_load ? load_data
                       : is_link ? (bus.PC_M + 32'd8)
                       : bus.ALU_M;
    assign bus.RegWr_W = bus.RegWr_M && !bus.adel && !bus.ades;
endmodule
